regalu_sequencer: RTL and testbench
===================================

Name: regalu_sequencer

Overview:
- Single-clock controller that sequences the register-file/ALU datapath through three phases: operand read, ALU flag/result capture, register writeback.
- Replaces the three free-running phase clocks (read-register, result-capture, writeback) with one-cycle enable strobes on the system clock.
- Accepts operation commands through a valid/ready handshake into a small command FIFO. Executes them back-to-back, one op per 3 cycles at steady state.

Parameters:
- FIFO_DEPTH, 2, command FIFO entries (power of 2, ≥2)
- ADDR_W, 5, register address width
- OP_W, 4, ALU opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_addr_a  in  ADDR_W  read port A address
- cmd_addr_b  in  ADDR_W  read port B address
- cmd_waddr  in  ADDR_W  writeback address
- cmd_op  in  OP_W  ALU opcode
- cmd_wen  in  1  writeback requested
- rr_en  out  1  operand-register load strobe
- f_en  out  1  ALU result/flag capture strobe
- wb_en  out  1  register-file write-phase strobe
- reg_write  out  1  register-file write enable
- r_addr_a  out  ADDR_W  current op read address A
- r_addr_b  out  ADDR_W  current op read address B
- w_addr  out  ADDR_W  current op write address
- alu_op  out  OP_W  current op opcode
- busy  out  1  state != IDLE or FIFO non-empty
- done  out  1  one-cycle pulse at op completion
- ops_count  out  16  completed-op counter

Behaviour:
- Handshake: a push occurs on a rising edge with cmd_valid && cmd_ready. cmd_ready is low when the FIFO is full, so a push to a full FIFO is impossible. Push and pop in the same cycle leave the count unchanged. Command fields are ignored when no push occurs.
- FSM states: IDLE, READ, EXEC, WB. Encoding lives in the package.
  - IDLE: if FIFO non-empty, pop, latch the head into the current-op registers, go to READ. Otherwise stay.
  - READ: rr_en=1. Go to EXEC.
  - EXEC: f_en=1. Go to WB.
  - WB: wb_en=1, done=1, ops_count += 1. If FIFO non-empty, pop, latch, go to READ (no IDLE bubble). Otherwise go to IDLE.
- Strobes are decoded from the state register only (Moore). At most one of rr_en, f_en, wb_en is high in any cycle.
- reg_write = wb_en && cur_wen && (cur_waddr != 0). Writes to x0 are suppressed.
- r_addr_a, r_addr_b, w_addr, alu_op come from the current-op registers and hold stable from READ through WB.
- Latency: a handshake in cycle 0 with the FSM idle and FIFO empty gives rr_en in cycle 2, f_en in cycle 3, wb_en/done in cycle 4.
- Throughput: 3 cycles per op while the FIFO stays non-empty.
- ops_count wraps 0xFFFF → 0x0000.
- Reset values (asynchronous, immediate): state=IDLE, FIFO empty, cmd_ready=1, all strobes 0, reg_write=0, done=0, busy=0, ops_count=0, current-op registers 0.
- Reset mid-op: the op is abandoned with no write, and queued commands are flushed.

Optional Feature:
- Macro: REGALU_STEP_MODE_EN
- Defined:
  - Adds input port step (1 bit, synchronous pulse).
  - Transitions out of READ, EXEC and WB happen only in a cycle with step=1. IDLE→READ is unchanged.
  - Each strobe (rr_en/f_en/wb_en, and with wb_en also reg_write, done, ops_count increment) asserts only in the first cycle of its state, tracked by an entry flag, so each phase produces exactly one strobe regardless of dwell time.
- Undefined: no step port; free-running behaviour as above.

Decomposition:
- Package regalu_seq_pkg:
  - state enum/localparams (IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3)
  - command struct/field widths (addr_a, addr_b, waddr, op, wen)
  - X0_ADDR constant
- One sub-module, regalu_cmd_fifo: synchronous FIFO with FIFO_DEPTH entries and a count, same clk/rst_n, push/pop/full/empty, head exposed combinationally.

Test Plan:
- Reset: hold rst_n=0 → all outputs at reset values, cmd_ready=1. Release rst_n → stays IDLE with busy=0.
- Single op: push {a=1,b=2,w=3,op=4'h0,wen=1} in cycle 0 → rr_en cycle 2, f_en cycle 3, wb_en=reg_write=done=1 cycle 4 with w_addr=3, ops_count=1.
- x0 suppression: push {w=0,wen=1} → wb_en=1, reg_write=0. Push {w=5,wen=0} → reg_write=0. ops_count still increments.
- Back-to-back/full: push 3 cmds on consecutive cycles → cmd_ready drops while FIFO holds 2. wb_en in cycles 4, 7, 10 with no IDLE bubble, addresses matching push order. ops_count=3.
- Reset mid-op: assert rst_n=0 during EXEC with 1 queued cmd → strobes low immediately, no reg_write. After release, no further strobes, ops_count=0.
- Step mode (macro defined): push 1 op, hold step=0 for 5 cycles in READ → rr_en high exactly 1 cycle, state held. Step pulses then advance EXEC and WB, each with a single strobe.

Source files
------------

// File: rtl/regalu_seq_pkg.sv
// Shared types and constants for the register-file/ALU phase sequencer.
package regalu_seq_pkg;

  localparam int CMD_ADDR_W = 5;
  localparam int CMD_OP_W   = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  // Register x0 is hardwired to zero, so writes to it are dropped.
  localparam int X0_ADDR = 0;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr_a;
    logic [CMD_ADDR_W-1:0] addr_b;
    logic [CMD_ADDR_W-1:0] waddr;
    logic [CMD_OP_W-1:0]   op;
    logic                  wen;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/regalu_sequencer_if.sv
// Command handshake and datapath control bundle of the phase sequencer.
interface regalu_sequencer_if #(
  parameter int ADDR_W = regalu_seq_pkg::CMD_ADDR_W,
  parameter int OP_W   = regalu_seq_pkg::CMD_OP_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic [ADDR_W-1:0] cmd_waddr;
  logic [OP_W-1:0]   cmd_op;
  logic              cmd_wen;
  logic              rr_en;
  logic              f_en;
  logic              wb_en;
  logic              reg_write;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] w_addr;
  logic [OP_W-1:0]   alu_op;
  logic              busy;
  logic              done;
  logic [15:0]       ops_count;

  modport master (
    output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_waddr, cmd_op, cmd_wen,
    input  cmd_ready, rr_en, f_en, wb_en, reg_write, r_addr_a, r_addr_b,
           w_addr, alu_op, busy, done, ops_count
  );

  modport slave (
    input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_waddr, cmd_op, cmd_wen,
    output cmd_ready, rr_en, f_en, wb_en, reg_write, r_addr_a, r_addr_b,
           w_addr, alu_op, busy, done, ops_count
  );
endinterface

// File: rtl/regalu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally.
module regalu_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/regalu_sequencer.sv
// Sequences operand read, ALU capture and writeback as one-cycle strobes.
// Optional single-step control is built when REGALU_STEP_MODE_EN is defined.
//
// state | meaning
// IDLE  | no op in flight; pops the FIFO head when one is queued
// READ  | rr_en: operand registers load from r_addr_a/r_addr_b
// EXEC  | f_en: ALU result and flags captured
// WB    | wb_en/done: writeback, then chain straight into the next op
module regalu_sequencer
  import regalu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int OP_W       = CMD_OP_W
) (
  input logic clk,
  input logic rst_n,
`ifdef REGALU_STEP_MODE_EN
  input logic step,
`endif
  regalu_sequencer_if.slave bus
);
  localparam int CW = 3*ADDR_W + OP_W + 1;

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               cur_q, cur_d;
  logic [15:0]                 ops_count_q, ops_count_d;
  logic [CW-1:0]               fifo_head, fifo_wdata;
  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        advance, first, cur_wen;

`ifdef REGALU_STEP_MODE_EN
  // Strobes fire only on the first cycle of a state, however long it dwells.
  logic entry_q, entry_d;
  assign advance = step;
  assign first   = entry_q;
  assign entry_d = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= 1'b0;
    else        entry_q <= entry_d;
  end
`else
  assign advance = 1'b1;
  assign first   = 1'b1;
`endif

  assign fifo_wdata = {bus.cmd_addr_a, bus.cmd_addr_b, bus.cmd_waddr, bus.cmd_op, bus.cmd_wen};

  regalu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {bus.r_addr_a, bus.r_addr_b, bus.w_addr, bus.alu_op, cur_wen} = cur_q;

  assign bus.cmd_ready = !fifo_full;
  assign bus.rr_en     = (state_q == READ) && first;
  assign bus.f_en      = (state_q == EXEC) && first;
  assign bus.wb_en     = (state_q == WB) && first;
  assign bus.done      = bus.wb_en;
  assign bus.reg_write = bus.wb_en && cur_wen && (bus.w_addr != ADDR_W'(X0_ADDR));
  assign bus.busy      = (state_q != IDLE) || (fifo_count != '0);
  assign bus.ops_count = ops_count_q;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    ops_count_d = ops_count_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = READ;
        end
      end
      READ: if (advance) state_d = EXEC;
      EXEC: if (advance) state_d = WB;
      default: begin
        if (bus.wb_en) ops_count_d = ops_count_q + 16'd1;
        if (advance) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
            state_d  = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      ops_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      ops_count_q <= ops_count_d;
    end
  end

endmodule

// File: tb/tb_regalu_sequencer.sv
// Bench for regalu_sequencer: timeline reference model of op issue/completion.
module tb_regalu_sequencer;
  import regalu_seq_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regalu_sequencer_if #(.ADDR_W(CMD_ADDR_W), .OP_W(CMD_OP_W)) bus ();

`ifdef REGALU_STEP_MODE_EN
  logic step;
`endif

  regalu_sequencer #(.FIFO_DEPTH(DEPTH), .ADDR_W(CMD_ADDR_W), .OP_W(CMD_OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef REGALU_STEP_MODE_EN
    .step  (step),
`endif
    .bus   (bus.slave)
  );

  // Each accepted op is described by when it was pushed and when its WB cycle is.
  typedef struct {
    cmd_t cmd;
    int   push_c;
    int   wb_c;
  } op_t;

  op_t ops[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  model_ready;

  task automatic chk(input string tag, input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s/%s got %0h want %0h", tag, name, got, exp);
    end
  endtask

  function automatic int model_ops_count();
    int n = 0;
    foreach (ops[i]) if (ops[i].wb_c < cyc) n++;
    return n;
  endfunction

  task automatic check_cycle(input string tag);
    logic e_rr, e_f, e_wb, e_rw, act;
    int   occ, ndone;
    cmd_t cur;
    e_rr = 0; e_f = 0; e_wb = 0; e_rw = 0; act = 0;
    occ = 0; ndone = 0; cur = '0;
    foreach (ops[i]) begin
      if (ops[i].push_c < cyc && cyc <= ops[i].wb_c - 3) occ++;
      if (ops[i].wb_c < cyc) ndone++;
      if (ops[i].wb_c - 2 <= cyc) cur = ops[i].cmd;
      if (cyc >= ops[i].wb_c - 2 && cyc <= ops[i].wb_c) act = 1;
      if (cyc == ops[i].wb_c - 2) e_rr = 1;
      if (cyc == ops[i].wb_c - 1) e_f = 1;
      if (cyc == ops[i].wb_c) begin
        e_wb = 1;
        e_rw = ops[i].cmd.wen && (ops[i].cmd.waddr != CMD_ADDR_W'(X0_ADDR));
      end
    end
    model_ready = (occ < DEPTH);
    chk(tag, "cmd_ready", 32'(bus.cmd_ready), 32'(model_ready));
    chk(tag, "rr_en",     32'(bus.rr_en),     32'(e_rr));
    chk(tag, "f_en",      32'(bus.f_en),      32'(e_f));
    chk(tag, "wb_en",     32'(bus.wb_en),     32'(e_wb));
    chk(tag, "done",      32'(bus.done),      32'(e_wb));
    chk(tag, "reg_write", 32'(bus.reg_write), 32'(e_rw));
    chk(tag, "busy",      32'(bus.busy),      32'(act || occ > 0));
    chk(tag, "r_addr_a",  32'(bus.r_addr_a),  32'(cur.addr_a));
    chk(tag, "r_addr_b",  32'(bus.r_addr_b),  32'(cur.addr_b));
    chk(tag, "w_addr",    32'(bus.w_addr),    32'(cur.waddr));
    chk(tag, "alu_op",    32'(bus.alu_op),    32'(cur.op));
    chk(tag, "ops_count", 32'(bus.ops_count), ndone & 32'hFFFF);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, record any push.
  task automatic tick(input logic v, input cmd_t c, input string tag);
    op_t o;
    bus.cmd_valid  = v;
    bus.cmd_addr_a = c.addr_a;
    bus.cmd_addr_b = c.addr_b;
    bus.cmd_waddr  = c.waddr;
    bus.cmd_op     = c.op;
    bus.cmd_wen    = c.wen;
    @(negedge clk);
    check_cycle(tag);
    if (v && model_ready && rst_n) begin
      o.cmd    = c;
      o.push_c = cyc;
      o.wb_c   = cyc + 4;
      if (ops.size() > 0 && ops[$].wb_c + 3 > o.wb_c) o.wb_c = ops[$].wb_c + 3;
      ops.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic cmd_t mk(input int a, input int b, input int w, input int op, input bit wen);
    cmd_t c;
    c.addr_a = CMD_ADDR_W'(a);
    c.addr_b = CMD_ADDR_W'(b);
    c.waddr  = CMD_ADDR_W'(w);
    c.op     = CMD_OP_W'(op);
    c.wen    = wen;
    return c;
  endfunction

  initial begin
    cmd_t        c;
    logic [31:0] r;
    int          base;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr_a = '0; bus.cmd_addr_b = '0; bus.cmd_waddr = '0;
    bus.cmd_op = '0; bus.cmd_wen = 1'b0;
`ifdef REGALU_STEP_MODE_EN
    step = 1'b1;
`endif

    // Reset held: garbage on the command bus must not be accepted.
    bus.cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_cycle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick(1'b0, '0, "idle");

    // Single op: rr_en at +2, f_en at +3, wb_en at +4.
    tick(1'b1, mk(1, 2, 3, 0, 1'b1), "single");
    repeat (6) tick(1'b0, '0, "single");
    chk("single", "ops_count_abs", 32'(bus.ops_count), 32'd1);

    // Writes to x0 and non-writing ops still complete and count.
    tick(1'b1, mk(4, 6, 0, 5, 1'b1), "x0");
    repeat (5) tick(1'b0, '0, "x0");
    tick(1'b1, mk(7, 8, 5, 9, 1'b0), "nowen");
    repeat (5) tick(1'b0, '0, "nowen");
    chk("x0", "ops_count_abs", 32'(bus.ops_count), 32'd3);

    // Three consecutive pushes fill the FIFO and run back to back.
    tick(1'b1, mk(10, 11, 12, 1, 1'b1), "b2b");
    tick(1'b1, mk(13, 14, 15, 2, 1'b1), "b2b");
    tick(1'b1, mk(16, 17, 18, 3, 1'b1), "b2b");
    repeat (10) tick(1'b0, '0, "b2b");
    chk("b2b", "ops_count_abs", 32'(bus.ops_count), 32'd6);

    // Random traffic, including offers while the FIFO is full.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      c = r[CMD_W-1:0];
      tick(($urandom_range(0, 9) < 6), c, "rand");
    end
    repeat (12) tick(1'b0, '0, "drain");

    // Reset during EXEC with one op still queued.
    tick(1'b1, mk(3, 4, 20, 6, 1'b1), "rst_mid");
    tick(1'b1, mk(5, 6, 21, 7, 1'b1), "rst_mid");
    tick(1'b0, '0, "rst_mid");
    rst_n = 1'b0;
    ops.delete();
    @(negedge clk);
    check_cycle("rst_mid_async");
    @(posedge clk);
    #1;
    cyc++;
    repeat (2) tick(1'b0, '0, "rst_hold");
    rst_n = 1'b1;
    repeat (8) tick(1'b0, '0, "post_rst");
    chk("post_rst", "ops_count_abs", 32'(bus.ops_count), 32'd0);

`ifdef REGALU_STEP_MODE_EN
    // Dwell in READ for five cycles, then single-step EXEC and WB.
    base = model_ops_count();
    for (int s = 0; s <= 12; s++) begin
      bus.cmd_valid  = (s == 0);
      bus.cmd_addr_a = 5'd7;
      bus.cmd_addr_b = 5'd8;
      bus.cmd_waddr  = 5'd9;
      bus.cmd_op     = 4'd3;
      bus.cmd_wen    = 1'b1;
      step = (s == 7 || s == 9 || s == 11);
      @(negedge clk);
      chk("step", "rr_en",     32'(bus.rr_en),     32'(s == 2));
      chk("step", "f_en",      32'(bus.f_en),      32'(s == 8));
      chk("step", "wb_en",     32'(bus.wb_en),     32'(s == 10));
      chk("step", "done",      32'(bus.done),      32'(s == 10));
      chk("step", "reg_write", 32'(bus.reg_write), 32'(s == 10));
      chk("step", "busy",      32'(bus.busy),      32'(s >= 1 && s <= 11));
      chk("step", "ops_count", 32'(bus.ops_count), 32'(base + ((s >= 11) ? 1 : 0)));
      if (s >= 2) chk("step", "w_addr", 32'(bus.w_addr), 32'd9);
      @(posedge clk);
      #1;
    end
    step = 1'b1;
`else
    base = model_ops_count();
    chk("final", "ops_count", 32'(bus.ops_count), 32'(base));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
